enc_8to3_seq: RTL and testbench
===============================

ENC_8TO3_SEQ -- requirements
Module: enc_8to3_seq

Interface
REQ-001 The block SHALL have one parameter: LSB_FIRST, default 1, scan order (1 = lowest set bit first, 0 = highest set bit first).
REQ-002 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit, the reset; asynchronous, active-low.
REQ-004 The block SHALL have the port en, input, 1 bit, global enable; 0 freezes the block.
REQ-005 The block SHALL have the port in_valid, input, 1 bit, a valid 8-bit vector is present on a.
REQ-006 The block SHALL have the port a, input, 8 bits, the vector to encode (decoded or request form).
REQ-007 The block SHALL have the port in_ready, output, 1 bit, the block accepts a vector this cycle.
REQ-008 The block SHALL have the port out_valid, output, 1 bit, out/out_last/zero are valid.
REQ-009 The block SHALL have the port out_ready, input, 1 bit, the consumer accepts the current beat.
REQ-010 The block SHALL have the port out, output, 3 bits, the index of the current set bit.
REQ-011 The block SHALL have the port out_last, output, 1 bit, the current beat is the final beat of the vector.
REQ-012 The block SHALL have the port cnt, output, 4 bits, the popcount (0..8) of the latched vector.
REQ-013 The block SHALL have the port zero, output, 1 bit, the current beat represents an all-zero vector.

Function
REQ-014 The block SHALL be an FSM with two states: IDLE and SCAN.
REQ-015 In IDLE, in_ready SHALL equal en, and out_valid SHALL be 0.
REQ-016 An accept (in_valid & in_ready) SHALL latch a into an 8-bit pending register (pend) and its popcount into cnt.
REQ-017 On an accept, the FSM SHALL enter SCAN if a != 0; an all-zero a is handled per REQ-030/031.
REQ-018 In SCAN, in_ready SHALL be 0; no overlap between vectors.
REQ-019 In SCAN, out_valid SHALL equal en.
REQ-020 In SCAN, out SHALL be the index of the lowest set bit of pend (LSB_FIRST=1) or of the highest set bit (LSB_FIRST=0).
REQ-021 out_last SHALL be 1 when exactly one bit of pend remains set.
REQ-022 Latency: the first beat SHALL be valid in the cycle after the accept; each subsequent beat SHALL be valid in the cycle after the previous transfer.
REQ-023 A transfer (out_valid & out_ready) SHALL clear the indexed bit in pend; a transfer with out_last=1 SHALL return the FSM to IDLE.
REQ-024 With out_valid=1 and out_ready=0, out, out_last and zero SHALL hold stable.
REQ-025 cnt SHALL hold its value from the accept until the next accept; it SHALL NOT decrement.
REQ-026 en=0 SHALL hold the state, pend and cnt, and SHALL force in_ready=0 and out_valid=0; operation resumes unchanged when en returns to 1.
REQ-027 The number of beats per vector SHALL equal popcount(a); a=8'hFF SHALL yield 8 beats, in order 0..7 (LSB_FIRST=1) or 7..0 (LSB_FIRST=0).

Reset
REQ-028 While rst_n=0, the block SHALL force: state=IDLE, pend=0, cnt=0, out=0, out_last=0, zero=0, out_valid=0, in_ready=0.
REQ-029 Reset asserted mid-SCAN SHALL drop the remaining beats; after release, the first cycle SHALL have in_ready=en.

Configuration
REQ-030 With macro ENC_ZERO_FLAG_EN defined, an accepted all-zero a SHALL enter SCAN and produce exactly one beat with out=0, zero=1, out_last=1 and cnt=0, then return to IDLE.
REQ-031 Without ENC_ZERO_FLAG_EN, an accepted all-zero a SHALL be dropped: the FSM stays in IDLE, no beat is produced, cnt=0, and zero is tied to 0.

Verification
REQ-032 The bench SHALL cover: reset, en=1, a=8'b0010_0100 accepted, out_ready=1 -> beats out=2 (out_last=0) then out=5 (out_last=1); cnt=2; in_ready=1 in the following cycle.
REQ-033 The bench SHALL cover: LSB_FIRST=0, a=8'hFF, out_ready=1 -> 8 consecutive beats out=7..0, out_last only on out=0, cnt=8.
REQ-034 The bench SHALL cover: a=8'h81, out_ready=0 for 3 cycles -> out=0 held stable with out_valid=1, then out=0, out=7 once out_ready=1.
REQ-035 The bench SHALL cover: mid-scan of a=8'h0F, en=0 for 2 cycles -> out_valid=0 and in_ready=0; scan resumes at the same index when en=1.
REQ-036 The bench SHALL cover: a=8'h00 accepted -> one beat zero=1/out=0 with ENC_ZERO_FLAG_EN defined; no beat and in_ready=1 next cycle without it.
REQ-037 The bench SHALL cover: rst_n pulled low after the first beat of a=8'h18 -> all outputs 0 asynchronously, no further beats, clean accept of a=8'h02 after release (out=1, out_last=1).

Source files
------------

// File: rtl/enc_8to3_seq.sv
// Sequential 8-to-3 encoder: latches a vector and emits one beat per set bit.
// Optional ENC_ZERO_FLAG_EN turns an all-zero vector into a single zero beat.
module enc_8to3_seq #(
  parameter int LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_valid,
  input  logic [7:0] a,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out,
  output logic       out_last,
  output logic [3:0] cnt,
  output logic       zero
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_pend;
  logic [7:0] w_pend_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [3:0] w_pop;
  logic [2:0] w_idx;
  logic       w_one;
  logic       w_scan;
  logic       w_last;
  logic       w_zero;

  assign w_scan = (r_state == SCAN);

  always_comb begin
    w_pop = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_pop = w_pop + {3'd0, a[i]};
    end
  end

  // Later loop iterations win, so scan direction picks the priority end.
  always_comb begin
    w_idx = 3'd0;
    if (LSB_FIRST != 0) begin
      for (int i = 7; i >= 0; i--) begin
        if (r_pend[i]) w_idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (r_pend[i]) w_idx = 3'(i);
      end
    end
  end

  assign w_one = (r_pend != 8'd0) &&
                 ((r_pend & (r_pend - 8'd1)) == 8'd0);

`ifdef ENC_ZERO_FLAG_EN
  logic r_zero;
  logic w_zero_nxt;

  assign w_zero = r_zero;
`else
  assign w_zero = 1'b0;
`endif

  assign w_last = w_scan & (w_one | w_zero);

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_cnt_nxt   = r_cnt;
`ifdef ENC_ZERO_FLAG_EN
    w_zero_nxt  = r_zero;
`endif
    if (en) begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            w_pend_nxt = a;
            w_cnt_nxt  = w_pop;
`ifdef ENC_ZERO_FLAG_EN
            w_zero_nxt  = (a == 8'd0);
            w_state_nxt = SCAN;
`else
            if (a != 8'd0) w_state_nxt = SCAN;
`endif
          end
        end
        SCAN: begin
          if (out_ready) begin
            w_pend_nxt = r_pend & ~(8'd1 << w_idx);
            if (w_last) begin
              w_state_nxt = IDLE;
`ifdef ENC_ZERO_FLAG_EN
              w_zero_nxt  = 1'b0;
`endif
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pend  <= 8'd0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef ENC_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_zero <= 1'b0;
    else        r_zero <= w_zero_nxt;
  end
`endif

  assign in_ready  = rst_n & en & ~w_scan;
  assign out_valid = en & w_scan;
  assign out       = w_idx;
  assign out_last  = w_last;
  assign cnt       = r_cnt;
  assign zero      = w_scan & w_zero;

endmodule

// File: tb/tb_enc_8to3_seq.sv
// Directed bench for enc_8to3_seq; runs LSB-first and MSB-first
// instances side by side on shared inputs.
module tb_enc_8to3_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic [7:0] a;
  logic       out_ready;

  logic       l_in_ready, l_out_valid, l_out_last, l_zero;
  logic [2:0] l_out;
  logic [3:0] l_cnt;
  logic       m_in_ready, m_out_valid, m_out_last, m_zero;
  logic [2:0] m_out;
  logic [3:0] m_cnt;

  int checks = 0;
  int failures = 0;

  enc_8to3_seq #(.LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .a(a),
    .in_ready(l_in_ready), .out_valid(l_out_valid),
    .out_ready(out_ready), .out(l_out),
    .out_last(l_out_last), .cnt(l_cnt), .zero(l_zero)
  );

  enc_8to3_seq #(.LSB_FIRST(0)) u_msb (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .a(a),
    .in_ready(m_in_ready), .out_valid(m_out_valid),
    .out_ready(out_ready), .out(m_out),
    .out_last(m_out_last), .cnt(m_cnt), .zero(m_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    int         n;
    int         fl;
    int         fm;
    int         ll;
    int         lm;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic int lo(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int hi(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] v);
    @(negedge clk);
    a = v;
    in_valid = 1'b1;
    #1;
    chk("acc_in_ready_l", int'(l_in_ready), 1);
    chk("acc_in_ready_m", int'(m_in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'd0;
    #1;
  endtask

  task automatic run_vec(input vec_t t);
    logic [7:0] sl;
    logic [7:0] sm;
    sl = t.a;
    sm = t.a;
    out_ready = 1'b1;
    accept(t.a);
    for (int k = 0; k < t.n; k++) begin
      chk("beat_valid_l", int'(l_out_valid), 1);
      chk("beat_valid_m", int'(m_out_valid), 1);
      chk("beat_out_l", int'(l_out), lo(sl));
      chk("beat_out_m", int'(m_out), hi(sm));
      if (k == 0) begin
        chk("first_l", int'(l_out), t.fl);
        chk("first_m", int'(m_out), t.fm);
      end
      if (k == t.n - 1) begin
        chk("final_l", int'(l_out), t.ll);
        chk("final_m", int'(m_out), t.lm);
      end
      chk("beat_last_l", int'(l_out_last), int'(k == t.n - 1));
      chk("beat_last_m", int'(m_out_last), int'(k == t.n - 1));
      chk("beat_cnt", int'(l_cnt), t.n);
      chk("beat_zero", int'(l_zero), 0);
      sl[lo(sl)] = 1'b0;
      sm[hi(sm)] = 1'b0;
      step();
    end
    chk("post_valid_l", int'(l_out_valid), 0);
    chk("post_ready_l", int'(l_in_ready), 1);
    chk("post_ready_m", int'(m_in_ready), 1);
    chk("post_cnt_m", int'(m_cnt), t.n);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{a: 8'b0010_0100, n: 2, fl: 2, fm: 5, ll: 5, lm: 2};
    tbl[1] = '{a: 8'hFF, n: 8, fl: 0, fm: 7, ll: 7, lm: 0};
    tbl[2] = '{a: 8'h01, n: 1, fl: 0, fm: 0, ll: 0, lm: 0};
    tbl[3] = '{a: 8'h80, n: 1, fl: 7, fm: 7, ll: 7, lm: 7};
    tbl[4] = '{a: 8'hA5, n: 4, fl: 0, fm: 7, ll: 7, lm: 0};
    tbl[5] = '{a: 8'h3C, n: 4, fl: 2, fm: 5, ll: 5, lm: 2};

    rst_n = 1'b0;
    en = 1'b1;
    in_valid = 1'b0;
    a = 8'd0;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", int'(l_in_ready), 0);
    chk("rst_out_valid", int'(l_out_valid), 0);
    chk("rst_out", int'(l_out), 0);
    chk("rst_last", int'(l_out_last), 0);
    chk("rst_cnt", int'(l_cnt), 0);
    chk("rst_zero", int'(l_zero), 0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", int'(l_in_ready), 1);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Output stall: 8'h81 held for three cycles.
    out_ready = 1'b0;
    accept(8'h81);
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", int'(l_out_valid), 1);
      chk("stall_out_l", int'(l_out), 0);
      chk("stall_out_m", int'(m_out), 7);
      chk("stall_last", int'(l_out_last), 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("stall_b0_l", int'(l_out), 0);
    chk("stall_b0_m", int'(m_out), 7);
    step();
    chk("stall_b1_l", int'(l_out), 7);
    chk("stall_b1_m", int'(m_out), 0);
    chk("stall_b1_last", int'(l_out_last), 1);
    step();
    chk("stall_done", int'(l_out_valid), 0);

    // Enable freeze mid-scan of 8'h0F.
    accept(8'h0F);
    chk("en_b0_l", int'(l_out), 0);
    chk("en_b0_m", int'(m_out), 3);
    @(negedge clk);
    en = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("en_off_valid", int'(l_out_valid), 0);
      chk("en_off_ready", int'(l_in_ready), 0);
      chk("en_off_cnt", int'(l_cnt), 4);
      step();
    end
    en = 1'b1;
    #1;
    chk("en_res_valid", int'(l_out_valid), 1);
    chk("en_res_l", int'(l_out), 1);
    chk("en_res_m", int'(m_out), 2);
    step();
    chk("en_b2_l", int'(l_out), 2);
    chk("en_b2_m", int'(m_out), 1);
    step();
    chk("en_b3_l", int'(l_out), 3);
    chk("en_b3_last", int'(l_out_last), 1);
    step();
    chk("en_done", int'(l_out_valid), 0);

    // All-zero vector.
    accept(8'h00);
`ifdef ENC_ZERO_FLAG_EN
    chk("z_valid", int'(l_out_valid), 1);
    chk("z_zero", int'(l_zero), 1);
    chk("z_out", int'(l_out), 0);
    chk("z_last", int'(l_out_last), 1);
    chk("z_cnt", int'(l_cnt), 0);
    step();
    chk("z_done", int'(l_out_valid), 0);
    chk("z_ready", int'(l_in_ready), 1);
`else
    chk("z_valid", int'(l_out_valid), 0);
    chk("z_ready", int'(l_in_ready), 1);
    chk("z_zero", int'(l_zero), 0);
    chk("z_cnt", int'(l_cnt), 0);
`endif

    // Reset after the first beat of 8'h18.
    accept(8'h18);
    chk("r_b0_l", int'(l_out), 3);
    chk("r_b0_m", int'(m_out), 4);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_valid", int'(l_out_valid), 0);
    chk("r_out", int'(l_out), 0);
    chk("r_last", int'(m_out_last), 0);
    chk("r_cnt", int'(l_cnt), 0);
    chk("r_ready", int'(l_in_ready), 0);
    chk("r_zero", int'(l_zero), 0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("r_hold_valid", int'(m_out_valid), 0);
    end
    rst_n = 1'b1;
    #1;
    chk("r_rel_ready", int'(l_in_ready), 1);
    chk("r_rel_valid", int'(l_out_valid), 0);
    accept(8'h02);
    chk("r_new_l", int'(l_out), 1);
    chk("r_new_m", int'(m_out), 1);
    chk("r_new_last", int'(l_out_last), 1);
    chk("r_new_cnt", int'(l_cnt), 1);
    step();
    chk("r_new_done", int'(l_out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
